// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, command
// opcodes and default frame widths.
package spi_pkg;

  localparam int DEF_CMD_W  = 10;
  localparam int DEF_DATA_W = 8;

  // Command opcode, carried in cmd_data[CMD_W-1 -: 2]
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    TURN,
    READ,
    GAP
  } state_t;

endpackage

// File: rtl/spi_master_shifter.sv
// Parallel-load, MSB-first shift register with serial input and bit counter.
//   load/load_data : parallel load, clears the bit counter (wins over shift)
//   shift/sin      : shift left one place, sin enters at the LSB
//   q              : register contents
//   last           : counter has reached W-1 (the caller stops shifting here,
//                    so the counter never wraps)
module spi_master_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= load_data;
      cnt <= '0;
    end else if (shift) begin
      q   <= {q[W-2:0], sin};
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(W - 1));

endmodule

// File: rtl/spi_master.sv
// SPI master: takes {opcode, payload} commands on a valid/ready port, sends
// them MSB-first on MOSI under SS_n and, for rd_data commands, captures the
// DATA_W-bit reply from MISO. SCLK is clk itself, one bit per edge.
//
// Frame: START (1) + SHIFT (CMD_W) [+ TURN (TURN_CYC) + READ (DATA_W)]
//        then GAP (GAP_CYC) with SS_n high, then IDLE.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_data = {opcode, payload}
//   SS_n, MOSI, MISO      SPI pins
//   rd_valid, rd_data     one-cycle pulse with the captured read byte
//   busy                  ~cmd_ready
//   cmd_err               (SPI_MASTER_CMD_CHECK_EN only) rd_data rejected
//
// Build option SPI_MASTER_CMD_CHECK_EN: rd_data commands are only sent after
// an rd_addr command; otherwise they are dropped and cmd_err pulses.
module spi_master
  import spi_pkg::*;
#(
  parameter int CMD_W    = DEF_CMD_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TURN_CYC = 2,
  parameter int GAP_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
`ifdef SPI_MASTER_CMD_CHECK_EN
  ,
  output logic              cmd_err
`endif
);

  localparam int CNT_MAX = (TURN_CYC > GAP_CYC) ? TURN_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;      // TURN / GAP cycle counter
  logic [1:0]        op_q;
  logic              accept;
  logic              reject;
  logic              tx_shift, tx_last;
  logic              rx_shift, rx_last;
  logic [CMD_W-1:0]  tx_q;
  logic [DATA_W-1:0] rx_q;
  logic              unused_bits;

  // Only the next-bit tap of tx and the low bits of rx feed the datapath.
  assign unused_bits = ^{tx_q, rx_q};

`ifdef SPI_MASTER_CMD_CHECK_EN
  logic rd_addr_seen;

  // cmd_err blocks ready for its one cycle, so a rejected command still
  // produces a single-cycle ready drop with no frame.
  assign cmd_ready = (state == IDLE) && !cmd_err;
  assign reject    = (cmd_data[CMD_W-1 -: 2] == OP_RD_DATA) && !rd_addr_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_err      <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      cmd_err <= accept && reject;
      if (accept && (cmd_data[CMD_W-1 -: 2] == OP_RD_ADDR))
        rd_addr_seen <= 1'b1;
      else if ((state == READ) && rx_last)
        rd_addr_seen <= 1'b0;
    end
  end
`else
  assign cmd_ready = (state == IDLE);
  assign reject    = 1'b0;
`endif

  assign busy   = ~cmd_ready;
  assign accept = cmd_valid && cmd_ready;

  // tx holds still during START (MOSI already shows the MSB) and shifts
  // during SHIFT, MOSI taking the bit below the current MSB.
  assign tx_shift = (state == SHIFT) && !tx_last;
  assign rx_shift = (state == READ) && !rx_last;

  spi_master_shifter #(.W(CMD_W)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (cmd_data),
    .shift     (tx_shift),
    .sin       (1'b0),
    .q         (tx_q),
    .last      (tx_last)
  );

  spi_master_shifter #(.W(DATA_W)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data ('0),
    .shift     (rx_shift),
    .sin       (MISO),
    .q         (rx_q),
    .last      (rx_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= OP_WR_ADDR;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && !reject) begin
            op_q  <= cmd_data[CMD_W-1 -: 2];
            state <= START;
            SS_n  <= 1'b0;
            MOSI  <= cmd_data[CMD_W-1];
          end
        end
        START: state <= SHIFT;
        SHIFT: begin
          if (tx_last) begin
            cnt  <= '0;
            MOSI <= 1'b0;
            if (op_q == OP_RD_DATA) begin
              state <= TURN;
            end else begin
              state <= GAP;
              SS_n  <= 1'b1;
            end
          end else begin
            MOSI <= tx_q[CMD_W-2];
          end
        end
        TURN: begin
          if (cnt == CNT_W'(TURN_CYC - 1)) begin
            state <= READ;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READ: begin
          // Final sample goes straight into rd_data alongside the 7 shifted.
          if (rx_last) begin
            rd_data  <= {rx_q[DATA_W-2:0], MISO};
            rd_valid <= 1'b1;
            state    <= GAP;
            SS_n     <= 1'b1;
            cnt      <= '0;
          end
        end
        GAP: begin
          if (cnt == CNT_W'(GAP_CYC - 1)) state <= IDLE;
          else                            cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master at default parameters. A negedge monitor acts
// as the SPI slave (drives MISO during the read window) and records each
// frame's SS_n-low length, MOSI bit string and the SS_n-high run before it.
module tb_spi_master;

  localparam int CMD_W    = 10;
  localparam int DATA_W   = 8;
  localparam int TURN_CYC = 2;
  localparam int GAP_CYC  = 1;
  localparam int RD_FIRST = 2 + CMD_W + TURN_CYC;     // 14th SS_n-low cycle
  localparam int RD_LAST  = RD_FIRST + DATA_W - 1;    // 21st

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CMD_W-1:0]  cmd_data;
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
`ifdef SPI_MASTER_CMD_CHECK_EN
  logic              cmd_err;
`endif

  spi_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy)
`ifdef SPI_MASTER_CMD_CHECK_EN
    ,
    .cmd_err   (cmd_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model / frame monitor
  logic [7:0]  slave_byte = 8'h00;
  int          lowcnt = 0, highcnt = 0;
  int          last_low_len = 0, last_high_len = 0, prev_high_len = 0;
  int          frames = 0, rdv_cnt = 0, mosi_idle_err = 0, err_cnt = 0;
  logic [31:0] mosi_sh = '0, last_mosi = '0;

  always @(negedge clk) begin
    if (SS_n && MOSI) mosi_idle_err <= mosi_idle_err + 1;
    if (rd_valid) rdv_cnt <= rdv_cnt + 1;
`ifdef SPI_MASTER_CMD_CHECK_EN
    if (cmd_err) err_cnt <= err_cnt + 1;
`endif
    if (!SS_n) begin
      if (lowcnt == 0) begin
        prev_high_len <= last_high_len;
        last_high_len <= highcnt;
        mosi_sh       <= {31'b0, MOSI};
      end else begin
        mosi_sh <= {mosi_sh[30:0], MOSI};
      end
      lowcnt  <= lowcnt + 1;
      highcnt <= 0;
      if ((lowcnt + 1 >= RD_FIRST) && (lowcnt + 1 <= RD_LAST))
        MISO <= slave_byte[3'(RD_LAST - 1 - lowcnt)];
      else
        MISO <= 1'b0;
    end else begin
      if (lowcnt != 0) begin
        last_low_len <= lowcnt;
        last_mosi    <= mosi_sh;
        frames       <= frames + 1;
      end
      lowcnt  <= 0;
      highcnt <= highcnt + 1;
      MISO    <= 1'b0;
    end
  end

  int ready_lag;

  // Issue one command and wait for its frame and gap to finish.
  task automatic run_cmd(input logic [CMD_W-1:0] c);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    cmd_valid = 1'b1;
    cmd_data  = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!SS_n && n < 100) begin @(negedge clk); n++; end
    chk("frame_end_seen", 32'(n < 100), 1);
    ready_lag = 0;
    while (!cmd_ready && ready_lag < 100) begin @(negedge clk); ready_lag++; end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int bad, n, k, f0, r0;
    logic [CMD_W-1:0] cmds [3];

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state and quiet idle
    chk("rst_ss_n", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!SS_n || MOSI || rd_valid || !cmd_ready || busy) bad++;
    end
    chk("idle_20_cycles", bad, 0);

`ifdef SPI_MASTER_CMD_CHECK_EN
    // rd_data without a preceding rd_addr is dropped
    f0 = frames;
    cmd_valid = 1'b1;
    cmd_data  = 10'h300;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("err_pulse", cmd_err, 1);
    chk("err_ready_low", cmd_ready, 0);
    chk("err_ss_n", SS_n, 1);
    @(negedge clk);
    chk("err_clear", cmd_err, 0);
    chk("err_ready_back", cmd_ready, 1);
    repeat (20) @(negedge clk);
    chk("err_no_frame", frames - f0, 0);
`endif

    // wr_addr 0x0A5: START bit (= cmd[9]) followed by cmd[9:0]
    run_cmd(10'h0A5);
    chk("wa_ss_low_len", last_low_len, 11);
    chk("wa_mosi_bits", last_mosi, 32'h0A5);
    chk("wa_ready_lag", ready_lag, GAP_CYC);

    // rd_addr then rd_data; slave answers 0x5C in low cycles 14..21
    run_cmd(10'h233);
    chk("ra_ss_low_len", last_low_len, 11);
    chk("ra_mosi_bits", last_mosi, 32'h633);
    slave_byte = 8'h5C;
    r0 = rdv_cnt;
    run_cmd(10'h300);
    chk("rd_ss_low_len", last_low_len, 21);
    chk("rd_mosi_bits", last_mosi, 32'h1C0000);
    chk("rd_data_val", rd_data, 8'h5C);
    chk("rd_valid_pulses", rdv_cnt - r0, 1);
    chk("rd_ready_lag", ready_lag, GAP_CYC);
`ifdef SPI_MASTER_CMD_CHECK_EN
    chk("err_only_once", err_cnt, 1);
`endif

    // cmd_valid held through three frames. Frames are spaced by the GAP
    // cycles plus the IDLE cycle in which the next command is accepted.
    f0 = frames;
    cmds = '{10'h155, 10'h0C3, 10'h2AA};
    k = 0;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = cmds[0];
    while (n < 300) begin
      if (cmd_ready) begin
        if (k == 3) break;
        cmd_data = cmds[k];
        k++;
      end
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_frames", frames - f0, 3);
    chk("held_sep_1_2", prev_high_len, GAP_CYC + 1);
    chk("held_sep_2_3", last_high_len, GAP_CYC + 1);
    chk("held_last_mosi", last_mosi, 32'h6AA);
    chk("held_rd_data_kept", rd_data, 8'h5C);

    // Async reset at SHIFT bit 5 of a rd_data frame (cmd[4] = 1)
    slave_byte = 8'hA5;
    r0 = rdv_cnt;
    cmd_valid = 1'b1;
    cmd_data  = 10'h3D0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_ss_low", SS_n, 0);
    chk("mid_mosi_bit5", MOSI, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ss_n", SS_n, 1);
    chk("async_mosi", MOSI, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_no_rd_valid", rdv_cnt - r0, 0);
    chk("rst_rd_data_clr", rd_data, 0);
    chk("rst_idle_ready", cmd_ready, 1);

    run_cmd(10'h1FF);
    chk("wd_ss_low_len", last_low_len, 11);
    chk("wd_mosi_bits", last_mosi, 32'h1FF);
    chk("wd_no_rd_valid", rdv_cnt - r0, 0);

    chk("mosi_zero_when_ss_high", mosi_idle_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
